// File: rtl/fp_addsub_pipe.sv
// +----------------------------------------------------------------------------+
// | Module   : fp_addsub_pipe                                                  |
// | Purpose  : 3-stage pipelined IEEE-754-style add/subtract, RNE rounding,    |
// |            denormal flush, valid/ready handshake with full backpressure.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [W-1:0] num_a,
  input  logic [W-1:0] num_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] num_out
);

  // Working mantissa: hidden bit, fraction, guard, round, sticky.
  localparam int MW  = MAN_W + 4;
  localparam int SW  = MAN_W + 5;
  localparam int LZW = $clog2(MW + 1);
  // Signed working exponent, wide enough for exp - lzc to go negative.
  localparam int EW  = EXP_W + LZW + 1;
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [W-1:0]     QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic adv;

  logic             s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d, s1_sub_q, s1_sub_d;
  logic             s1_spec_q, s1_spec_d;
  logic [MW-1:0]    s1_man_l_q, s1_man_l_d, s1_man_s_q, s1_man_s_d;
  logic [EXP_W-1:0] s1_shift_q, s1_shift_d, s1_exp_q, s1_exp_d;
  logic [W-1:0]     s1_spec_val_q, s1_spec_val_d;

  logic             s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d, s2_spec_q, s2_spec_d;
  logic [SW-1:0]    s2_sum_q, s2_sum_d;
  logic [EXP_W-1:0] s2_exp_q, s2_exp_d;
  logic [W-1:0]     s2_spec_val_q, s2_spec_val_d;

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     num_out_q, num_out_d;

  // stage-1 temporaries
  logic             sa, sb_eff, zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, a_big;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic [W-2:0]     mag_a, mag_b;
  // stage-2 temporaries
  logic [MW-1:0]    s_aligned, s_mask;
  logic             s_sticky;
  // stage-3 temporaries
  logic [LZW-1:0]   lzc;
  logic             lz_found, rnd_up;
  logic [MW-1:0]    norm;
  logic [MAN_W+1:0] mant_r;
  logic [EW-1:0]    exp_n, exp_f;
  logic [W-1:0]     res;

  // The whole pipe moves together; it only freezes when the output is held.
  assign adv       = !out_valid_q | out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign num_out   = num_out_q;

  // Stage 1: unpack, classify specials, order operands by full magnitude.
  always_comb begin
    sa     = num_a[W-1];
    sb_eff = num_b[W-1] ^ op;
    ea     = num_a[W-2:MAN_W];
    eb     = num_b[W-2:MAN_W];
    fa     = num_a[MAN_W-1:0];
    fb     = num_b[MAN_W-1:0];
    zero_a = (ea == '0);
    zero_b = (eb == '0);
    inf_a  = (ea == EXP_ONES) && (fa == '0);
    inf_b  = (eb == EXP_ONES) && (fb == '0);
    nan_a  = (ea == EXP_ONES) && (fa != '0);
    nan_b  = (eb == EXP_ONES) && (fb != '0);
    mag_a  = zero_a ? '0 : num_a[W-2:0];
    mag_b  = zero_b ? '0 : num_b[W-2:0];
    a_big  = (mag_a >= mag_b);

    s1_valid_d = in_valid;
    s1_sub_d   = sa ^ sb_eff;
    s1_spec_d  = zero_a | zero_b | inf_a | inf_b | nan_a | nan_b;

    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb_eff)))
      s1_spec_val_d = QNAN;
    else if (inf_a)
      s1_spec_val_d = {sa, EXP_ONES, {MAN_W{1'b0}}};
    else if (inf_b)
      s1_spec_val_d = {sb_eff, EXP_ONES, {MAN_W{1'b0}}};
    else if (zero_a && zero_b)
      s1_spec_val_d = {sa & sb_eff, {(W-1){1'b0}}};
    else if (zero_a)
      s1_spec_val_d = {sb_eff, eb, fb};
    else
      s1_spec_val_d = {sa, ea, fa};

    if (a_big) begin
      s1_man_l_d = {1'b1, fa, 3'b000};
      s1_man_s_d = {1'b1, fb, 3'b000};
      s1_shift_d = ea - eb;
      s1_exp_d   = ea;
      s1_sign_d  = sa;
    end else begin
      s1_man_l_d = {1'b1, fb, 3'b000};
      s1_man_s_d = {1'b1, fa, 3'b000};
      s1_shift_d = eb - ea;
      s1_exp_d   = eb;
      s1_sign_d  = sb_eff;
    end
  end

  // Stage 2: align the smaller mantissa with sticky collection, then add/subtract.
  always_comb begin
    s_mask   = ~({MW{1'b1}} << s1_shift_q);
    s_sticky = |(s1_man_s_q & s_mask);
    if (32'(s1_shift_q) >= MW)
      s_aligned = {{(MW-1){1'b0}}, |s1_man_s_q};
    else
      s_aligned = (s1_man_s_q >> s1_shift_q) | {{(MW-1){1'b0}}, s_sticky};

    s2_valid_d    = s1_valid_q;
    s2_sum_d      = s1_sub_q ? ({1'b0, s1_man_l_q} - {1'b0, s_aligned})
                             : ({1'b0, s1_man_l_q} + {1'b0, s_aligned});
    s2_exp_d      = s1_exp_q;
    s2_sign_d     = s1_sign_q;
    s2_spec_d     = s1_spec_q;
    s2_spec_val_d = s1_spec_val_q;
  end

  // Stage 3: normalise, round to nearest even, detect overflow/underflow, pack.
  always_comb begin
    lzc      = '0;
    lz_found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!lz_found) begin
        if (s2_sum_q[i]) lz_found = 1'b1;
        else             lzc      = lzc + LZW'(1);
      end
    end

    if (s2_sum_q[SW-1]) begin
      norm  = {s2_sum_q[SW-1:2], s2_sum_q[1] | s2_sum_q[0]};
      exp_n = EW'(s2_exp_q) + EW'(1);
    end else begin
      norm  = s2_sum_q[MW-1:0] << lzc;
      exp_n = EW'(s2_exp_q) - EW'(lzc);
    end

    rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r = {1'b0, norm[MW-1:3]} + (MAN_W+2)'(rnd_up);
    exp_f  = exp_n + EW'(mant_r[MAN_W+1]);

    if (s2_spec_q)
      res = s2_spec_val_q;
    else if (s2_sum_q == '0)
      res = '0;
    else if ($signed(exp_f) <= 0)
      res = {s2_sign_q, {(W-1){1'b0}}};
    else if (exp_f >= EW'(EXP_ONES))
      res = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
    else
      res = {s2_sign_q, exp_f[EXP_W-1:0], mant_r[MAN_W-1:0]};

    out_valid_d = s2_valid_q;
    num_out_d   = s2_valid_q ? res : num_out_q;
  end

  // Pipeline registers; everything holds when the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_sub_q      <= 1'b0;
      s1_spec_q     <= 1'b0;
      s1_man_l_q    <= '0;
      s1_man_s_q    <= '0;
      s1_shift_q    <= '0;
      s1_exp_q      <= '0;
      s1_spec_val_q <= '0;
      s2_valid_q    <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_spec_q     <= 1'b0;
      s2_sum_q      <= '0;
      s2_exp_q      <= '0;
      s2_spec_val_q <= '0;
      out_valid_q   <= 1'b0;
      num_out_q     <= '0;
    end else if (adv) begin
      s1_valid_q    <= s1_valid_d;
      s1_sign_q     <= s1_sign_d;
      s1_sub_q      <= s1_sub_d;
      s1_spec_q     <= s1_spec_d;
      s1_man_l_q    <= s1_man_l_d;
      s1_man_s_q    <= s1_man_s_d;
      s1_shift_q    <= s1_shift_d;
      s1_exp_q      <= s1_exp_d;
      s1_spec_val_q <= s1_spec_val_d;
      s2_valid_q    <= s2_valid_d;
      s2_sign_q     <= s2_sign_d;
      s2_spec_q     <= s2_spec_d;
      s2_sum_q      <= s2_sum_d;
      s2_exp_q      <= s2_exp_d;
      s2_spec_val_q <= s2_spec_val_d;
      out_valid_q   <= out_valid_d;
      num_out_q     <= num_out_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_addsub_pipe.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_fp_addsub_pipe                                               |
// | Purpose  : Directed self-checking bench for fp_addsub_pipe (single and     |
// |            half-precision instances).                                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, op, out_valid, out_ready;
  logic [31:0] num_a, num_b, num_out;

  logic        h_in_valid, h_in_ready, h_op, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_out;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic [31:0] bp_a   [5] = '{32'h40400000, 32'h3F800000, 32'h3F800001, 32'h3FC00000, 32'h40400000};
  logic [31:0] bp_b   [5] = '{32'h3F800000, 32'h3FC00000, 32'h33800000, 32'h3FC00000, 32'h3F800000};
  logic        bp_op  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] bp_exp [5] = '{32'h40000000, 32'hBF000000, 32'h3F800002, 32'h40400000, 32'h40800000};

  logic [15:0] hv_a   [2] = '{16'h4200, 16'h3C00};
  logic [15:0] hv_b   [2] = '{16'h3C00, 16'h3C00};
  logic        hv_op  [2] = '{1'b1, 1'b0};
  logic [15:0] hv_exp [2] = '{16'h4000, 16'h4000};

  fp_addsub_pipe u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .num_a     (num_a),
    .num_b     (num_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .num_out   (num_out)
  );

  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) u_half (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (h_in_valid),
    .in_ready  (h_in_ready),
    .op        (h_op),
    .num_a     (h_a),
    .num_b     (h_b),
    .out_valid (h_out_valid),
    .out_ready (h_out_ready),
    .num_out   (h_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One isolated transaction with out_ready high; checks latency and result.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic o, input logic [31:0] exp);
    int lat;
    @(negedge clk);
    num_a = a; num_b = b; op = o; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd3);
    check(tag, num_out, exp);
  endtask

  initial begin
    int issued, got, cyc, seen, lat;
    logic        prev_stall;
    logic [31:0] prev_out;

    rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; out_ready = 1'b1;
    num_a = '0; num_b = '0;
    h_in_valid = 1'b0; h_op = 1'b0; h_out_ready = 1'b1; h_a = '0; h_b = '0;
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset num_out", num_out, 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // back-to-back pair, exact 3-cycle latency on consecutive cycles
    @(negedge clk);
    num_a = 32'h40400000; num_b = 32'h3F800000; op = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    num_a = 32'h3F800000; num_b = 32'h3F800000; op = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b early", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("b2b first valid", 32'(out_valid), 32'd1);
    check("b2b 3-1", num_out, 32'h40000000);
    @(posedge clk);
    @(negedge clk);
    check("b2b second valid", 32'(out_valid), 32'd1);
    check("b2b 1+1", num_out, 32'h40000000);
    @(posedge clk);
    @(negedge clk);
    check("b2b drained", 32'(out_valid), 32'd0);

    run_op("1-1.5",       32'h3F800000, 32'h3FC00000, 1'b1, 32'hBF000000);
    run_op("cancel",      32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000);
    run_op("deep cancel", 32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000);
    run_op("tie even",    32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000);
    run_op("tie odd",     32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002);
    run_op("overflow",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000);
    run_op("inf-inf",     32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000);
    run_op("-inf+1",      32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000);
    run_op("denorm+0",    32'h00000001, 32'h00000000, 1'b0, 32'h00000000);
    run_op("nan in",      32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000);
    run_op("-0-+0",       32'h80000000, 32'h00000000, 1'b1, 32'h80000000);
    run_op("0-x",         32'h00000000, 32'h40400000, 1'b1, 32'hC0400000);

    // backpressure with random out_ready
    issued = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_out = '0;
    while (got < 5 && cyc < 300) begin
      @(negedge clk);
      if (prev_stall) begin
        check("bp hold data", num_out, prev_out);
        check("bp hold valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (issued < 5);
      if (issued < 5) begin
        num_a = bp_a[issued]; num_b = bp_b[issued]; op = bp_op[issued];
      end
      #1;
      check("bp in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        check("bp result", num_out, bp_exp[got]);
        got++;
      end
      if (in_valid && in_ready) issued++;
      prev_stall = out_valid && !out_ready;
      prev_out   = num_out;
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp count", 32'(got), 32'd5);
    check("bp no extra", 32'(out_valid), 32'd0);

    // asynchronous reset with operations in flight
    for (int k = 0; k < 3; k++) begin
      num_a = 32'h3FC00000; num_b = 32'h3FC00000; op = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      if (k < 2) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst num_out", num_out, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no spurious after rst", 32'(seen), 32'd0);
    run_op("post rst 3-1", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000);

    // half-precision instance
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      h_a = hv_a[k]; h_b = hv_b[k]; h_op = hv_op[k]; h_in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      h_in_valid = 1'b0;
      lat = 1;
      while (!h_out_valid && lat < 10) begin
        @(posedge clk);
        @(negedge clk);
        lat++;
      end
      check("half latency", 32'(lat), 32'd3);
      check("half result", 32'(h_out), 32'(hv_exp[k]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
